// File: rtl/ddr3_input_packer.sv
// ddr3_input_packer
// Packs a non-stallable stream of DIN_WIDTH-bit samples into LINE_WIDTH-bit
// lines (LANES samples per line, lane 0 in the low bits) and hands each
// completed line to the DDR input mini-FIFO through a one-line holding
// register. Supports an end-of-run flush that pads the partial line, a sticky
// overflow flag and host-readable line/drop counters.
// LINE_WIDTH must equal DIN_WIDTH*LANES.
module ddr3_input_packer #(
    parameter int                   DIN_WIDTH   = 16,
    parameter int                   LINE_WIDTH  = 256,
    parameter int                   LANES       = 16,
    parameter logic [DIN_WIDTH-1:0] PAD_WORD    = 16'h0000,
    parameter int                   COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [DIN_WIDTH-1:0]   din,
    input  logic                   din_valid,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [LINE_WIDTH-1:0]  fifo_din,
    output logic                   fifo_we,
    input  logic                   fifo_full,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic [COUNT_WIDTH-1:0] line_count,
    output logic [COUNT_WIDTH-1:0] drop_count
);

    localparam int                   LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0]    LANE_ZERO = {LANE_W{1'b0}};
    localparam logic [LANE_W-1:0]    LANE_ONE  = LANE_W'(1'b1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1'b1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PAD   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Reset synchronizer: assert asynchronously, release on a clock edge.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n_s;

    logic [LANES-1:0][DIN_WIDTH-1:0] acc_q,  acc_d;
    logic [LANES-1:0][DIN_WIDTH-1:0] hold_q, hold_d;
    logic                            hold_valid_q, hold_valid_d;
    logic [LANE_W-1:0]               lane_q, lane_d;
    state_t                          state_q, state_d;
    logic                            flush_done_q, flush_done_d;
    logic                            overflow_q, overflow_d;
    logic [COUNT_WIDTH-1:0]          line_cnt_q, line_cnt_d;
    logic [COUNT_WIDTH-1:0]          drop_cnt_q, drop_cnt_d;

    logic sample_s;
    logic last_lane_s;
    logic accept_s;
    logic drop_s;
    logic we_s;
    logic pad_go_s;

    // Shift a one through the synchronizer once reset_n is released.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_s = rst_sync_q[1];

    // Per-cycle decisions: which sample is taken, which is lost, when the FIFO is written.
    always_comb begin
        sample_s    = enable && din_valid;
        last_lane_s = (lane_q == LAST_LANE);
        // The last lane is refused while the previous line still waits, since
        // completing it would have nowhere to go.
        accept_s    = sample_s && (state_q == S_RUN) && !(last_lane_s && hold_valid_q);
        drop_s      = sample_s && !accept_s;
        we_s        = hold_valid_q && !fifo_full;
        pad_go_s    = (state_q == S_PAD) && (!hold_valid_q || we_s);
    end

    // Next-state for accumulator, lane index, holding register and flush FSM.
    always_comb begin
        acc_d        = acc_q;
        lane_d       = lane_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        state_d      = state_q;
        flush_done_d = 1'b0;

        if (we_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        if (accept_s) begin
            acc_d[lane_q] = din;
            if (last_lane_s) begin
                lane_d       = LANE_ZERO;
                hold_d       = acc_d;
                hold_valid_d = 1'b1;
            end else begin
                lane_d = lane_q + LANE_ONE;
            end
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            S_RUN: begin
                // lane_d already reflects a sample accepted in this same cycle.
                if (flush) begin
                    if (lane_d != LANE_ZERO) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_PAD: begin
                if (pad_go_s) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (k >= int'(lane_q)) begin
                            hold_d[k] = PAD_WORD;
                        end else begin
                            hold_d[k] = acc_q[k];
                        end
                    end
                    hold_valid_d = 1'b1;
                    lane_d       = LANE_ZERO;
                    state_d      = S_DRAIN;
                end else begin
                    state_d = S_PAD;
                end
            end
            S_DRAIN: begin
                if (!hold_valid_q) begin
                    flush_done_d = 1'b1;
                    state_d      = S_RUN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Overflow flag and counters; a clear wins over a drop in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        line_cnt_d = line_cnt_q;

        if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = CNT_ZERO;
        end else if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_ONE;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end

        if (we_s) begin
            line_cnt_d = line_cnt_q + CNT_ONE;
        end else begin
            line_cnt_d = line_cnt_q;
        end
    end

    // State registers; reset discards any partial or pending line.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            acc_q        <= {(LANES*DIN_WIDTH){1'b0}};
            hold_q       <= {(LANES*DIN_WIDTH){1'b0}};
            hold_valid_q <= 1'b0;
            lane_q       <= LANE_ZERO;
            state_q      <= S_RUN;
            flush_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            line_cnt_q   <= CNT_ZERO;
            drop_cnt_q   <= CNT_ZERO;
        end else begin
            acc_q        <= acc_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            lane_q       <= lane_d;
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
            overflow_q   <= overflow_d;
            line_cnt_q   <= line_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign fifo_we    = we_s;
    assign fifo_din   = hold_q;
    assign flush_done = flush_done_q;
    assign overflow   = overflow_q;
    assign line_count = line_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_ddr3_input_packer.sv
// Self-checking bench for ddr3_input_packer: directed scenarios plus a random
// run, compared cycle by cycle against a queue-based line model.
module tb_ddr3_input_packer;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic [15:0]  din;
    logic         din_valid;
    logic         flush;
    logic         flush_done;
    logic [255:0] fifo_din;
    logic         fifo_we;
    logic         fifo_full;
    logic         overflow;
    logic         clear_overflow;
    logic [31:0]  line_count;
    logic [31:0]  drop_count;

    int errors = 0;
    int checks = 0;

    ddr3_input_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .din            (din),
        .din_valid      (din_valid),
        .flush          (flush),
        .flush_done     (flush_done),
        .fifo_din       (fifo_din),
        .fifo_we        (fifo_we),
        .fifo_full      (fifo_full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .line_count     (line_count),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: samples of the partial line, one pending line, flush phase.
    logic [15:0]  cur[$];
    bit           m_hv;
    logic [255:0] m_hline;
    int           m_phase;   // 0 running, 1 waiting to pad, 2 waiting to drain
    bit           m_fd;
    bit           m_ovf;
    logic [31:0]  m_lines;
    logic [31:0]  m_drops;

    // Values seen at the last tick and what the model predicted for them.
    bit           obs_we, obs_fd, obs_ovf, exp_we, exp_fd, exp_ovf;
    logic [255:0] obs_din, exp_din;
    logic [31:0]  obs_lines, obs_drops, exp_lines, exp_drops;

    function automatic logic [255:0] pack_line();
        logic [255:0] l;
        for (int k = 0; k < 16; k++)
            l[16*k +: 16] = (k < cur.size()) ? cur[k] : 16'h0000;
        cur.delete();
        return l;
    endfunction

    task automatic model_reset();
        cur.delete();
        m_hv = 0; m_hline = '0; m_phase = 0; m_fd = 0; m_ovf = 0;
        m_lines = 32'd0; m_drops = 32'd0;
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit fl, input bit full, input bit clr);
        enable = 1'b1; din_valid = v; din = d; flush = fl; fifo_full = full; clear_overflow = clr;
    endtask

    // One clock: snapshot DUT and model at the falling edge, then step the model.
    task automatic tick();
        bit smp, acc, drp, wr, hv_old;
        @(negedge clk);
        obs_we = fifo_we; obs_din = fifo_din; obs_fd = flush_done; obs_ovf = overflow;
        obs_lines = line_count; obs_drops = drop_count;
        exp_we = m_hv && !fifo_full; exp_din = m_hline; exp_fd = m_fd; exp_ovf = m_ovf;
        exp_lines = m_lines; exp_drops = m_drops;
        hv_old = m_hv; wr = exp_we;
        smp = enable && din_valid;
        acc = smp && (m_phase == 0) && !(cur.size() == 15 && hv_old);
        drp = smp && !acc;
        m_fd = 0;
        if (wr) begin m_hv = 0; m_lines = m_lines + 32'd1; end
        if (acc) begin
            cur.push_back(din);
            if (cur.size() == 16) begin m_hline = pack_line(); m_hv = 1; end
        end
        case (m_phase)
            0: if (flush) m_phase = (cur.size() != 0) ? 1 : 2;
            1: if (!hv_old || wr) begin m_hline = pack_line(); m_hv = 1; m_phase = 2; end
            2: if (!hv_old) begin m_fd = 1; m_phase = 0; end
            default: m_phase = 0;
        endcase
        if (clear_overflow) begin m_ovf = 0; m_drops = 32'd0; end
        else if (drp) begin
            m_ovf = 1;
            if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 16'h0000, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fifo_we, flush_done, overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: we/fd/ovf=%b want 000", {fifo_we, flush_done, overflow});
        end
        checks++;
        if ({fifo_din, line_count, drop_count} !== {256'd0, 32'd0, 32'd0}) begin
            errors++; $display("FAIL reset_data: din=%h lines=%0d drops=%0d want all zero", fifo_din, line_count, drop_count);
        end
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_two_lines();
        logic [255:0] first; bit got;
        got = 0; first = '0;
        for (int i = 0; i < 34; i++) begin
            drive(i < 32, 16'(i), 0, 0, 0);
            tick();
            checks++;
            if ({obs_we, obs_fd, obs_ovf, obs_lines, obs_drops} !== {exp_we, exp_fd, exp_ovf, exp_lines, exp_drops}) begin
                errors++;
                $display("FAIL two_lines c%0d: we=%b fd=%b ovf=%b lines=%0d drops=%0d want %b %b %b %0d %0d",
                         i, obs_we, obs_fd, obs_ovf, obs_lines, obs_drops, exp_we, exp_fd, exp_ovf, exp_lines, exp_drops);
            end
            if (exp_we) begin
                checks++;
                if (obs_din !== exp_din) begin errors++; $display("FAIL two_lines_din c%0d: %h want %h", i, obs_din, exp_din); end
            end
            if (obs_we && !got) begin got = 1; first = obs_din; end
        end
        checks++;
        if ({got, first[15:0], first[255:240]} !== {1'b1, 16'h0000, 16'h000F}) begin
            errors++; $display("FAIL two_lines_lanes: got=%b lane0=%h lane15=%h want 1 0000 000f", got, first[15:0], first[255:240]);
        end
        checks++;
        if ({line_count, overflow} !== {32'd2, 1'b0}) begin
            errors++; $display("FAIL two_lines_count: lines=%0d ovf=%b want 2 0", line_count, overflow);
        end
    endtask

    task automatic test_full_stall();
        int writes;
        writes = 0;
        for (int i = 0; i < 47; i++) begin
            if (i < 40)       drive(1, 16'h0100 + 16'(i), 0, 1, 0);
            else if (i == 43) drive(1, 16'h01FF, 0, 0, 0);
            else              drive(0, 16'h0000, 0, 0, 0);
            tick();
            checks++;
            if ({obs_we, obs_fd, obs_ovf, obs_lines, obs_drops} !== {exp_we, exp_fd, exp_ovf, exp_lines, exp_drops}) begin
                errors++;
                $display("FAIL full_stall c%0d: we=%b fd=%b ovf=%b lines=%0d drops=%0d want %b %b %b %0d %0d",
                         i, obs_we, obs_fd, obs_ovf, obs_lines, obs_drops, exp_we, exp_fd, exp_ovf, exp_lines, exp_drops);
            end
            if (exp_we) begin
                checks++;
                if (obs_din !== exp_din) begin errors++; $display("FAIL full_stall_din c%0d: %h want %h", i, obs_din, exp_din); end
            end
            if (i >= 40 && i < 43 && obs_we) writes++;
            if (i == 40) begin
                // Lane 15 of the second line is refused while line 1 waits, so
                // sample 31 is lost along with 32..39.
                checks++;
                if ({obs_ovf, obs_drops} !== {1'b1, 32'd9}) begin
                    errors++; $display("FAIL full_stall_drops: ovf=%b drops=%0d want 1 9", obs_ovf, obs_drops);
                end
            end
        end
        checks++;
        if (writes != 1) begin errors++; $display("FAIL full_stall_release: writes=%0d want 1", writes); end
    endtask

    task automatic test_flush_pad();
        int writes, pulses; logic [255:0] line;
        writes = 0; pulses = 0; line = '0;
        for (int i = 0; i < 14; i++) begin
            if (i < 5)       drive(1, 16'hA001 + 16'(i), 0, 0, 0);
            else if (i == 5) drive(0, 16'h0000, 1, 0, 0);
            else             drive(0, 16'h0000, 0, 0, 0);
            tick();
            checks++;
            if ({obs_we, obs_fd, obs_ovf, obs_lines, obs_drops} !== {exp_we, exp_fd, exp_ovf, exp_lines, exp_drops}) begin
                errors++;
                $display("FAIL flush_pad c%0d: we=%b fd=%b ovf=%b lines=%0d drops=%0d want %b %b %b %0d %0d",
                         i, obs_we, obs_fd, obs_ovf, obs_lines, obs_drops, exp_we, exp_fd, exp_ovf, exp_lines, exp_drops);
            end
            if (obs_we) begin writes++; line = obs_din; end
            if (obs_fd) pulses++;
        end
        checks++;
        if ({writes, pulses} !== {32'd1, 32'd1}) begin
            errors++; $display("FAIL flush_pad_events: writes=%0d pulses=%0d want 1 1", writes, pulses);
        end
        checks++;
        if (line !== {176'd0, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001}) begin
            errors++; $display("FAIL flush_pad_line: %h want padded A001..A005", line);
        end
    endtask

    task automatic test_flush_empty();
        int writes;
        writes = 0;
        for (int i = 0; i < 26; i++) begin
            if (i == 0)                drive(0, 16'h0000, 1, 0, 0);
            else if (i >= 4 && i < 20) drive(1, 16'hB000 + 16'(i), i == 19, 0, 0);
            else                       drive(0, 16'h0000, 0, 0, 0);
            tick();
            checks++;
            if ({obs_we, obs_fd, obs_ovf, obs_lines, obs_drops} !== {exp_we, exp_fd, exp_ovf, exp_lines, exp_drops}) begin
                errors++;
                $display("FAIL flush_empty c%0d: we=%b fd=%b ovf=%b lines=%0d drops=%0d want %b %b %b %0d %0d",
                         i, obs_we, obs_fd, obs_ovf, obs_lines, obs_drops, exp_we, exp_fd, exp_ovf, exp_lines, exp_drops);
            end
            if (exp_we) begin
                checks++;
                if (obs_din !== exp_din) begin errors++; $display("FAIL flush_empty_din c%0d: %h want %h", i, obs_din, exp_din); end
            end
            if (i == 2) begin
                checks++;
                if ({obs_we, obs_fd} !== 2'b01) begin errors++; $display("FAIL flush_empty_done: we/fd=%b want 01", {obs_we, obs_fd}); end
            end
            if (i >= 4 && obs_we) writes++;
        end
        checks++;
        if (writes != 1) begin errors++; $display("FAIL flush_with_last: writes=%0d want 1", writes); end
    endtask

    task automatic test_clear_overflow();
        for (int i = 0; i < 39; i++) begin
            if (i < 32)       drive(1, 16'hC000 + 16'(i), 0, 1, 0);
            else if (i == 32) drive(1, 16'hC0EE, 0, 1, 1);
            else if (i == 35) drive(1, 16'hC0FF, 0, 0, 0);
            else              drive(0, 16'h0000, 0, i < 34, 0);
            tick();
            checks++;
            if ({obs_we, obs_fd, obs_ovf, obs_lines, obs_drops} !== {exp_we, exp_fd, exp_ovf, exp_lines, exp_drops}) begin
                errors++;
                $display("FAIL clear_ovf c%0d: we=%b fd=%b ovf=%b lines=%0d drops=%0d want %b %b %b %0d %0d",
                         i, obs_we, obs_fd, obs_ovf, obs_lines, obs_drops, exp_we, exp_fd, exp_ovf, exp_lines, exp_drops);
            end
            if (exp_we) begin
                checks++;
                if (obs_din !== exp_din) begin errors++; $display("FAIL clear_ovf_din c%0d: %h want %h", i, obs_din, exp_din); end
            end
            if (i == 33) begin
                checks++;
                if ({obs_ovf, obs_drops} !== {1'b0, 32'd0}) begin
                    errors++; $display("FAIL clear_ovf_wins: ovf=%b drops=%0d want 0 0", obs_ovf, obs_drops);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] line; bit got;
        line = '0; got = 0;
        for (int i = 0; i < 23; i++) begin
            drive(1, 16'hD000 + 16'(i), 0, 1, 0);
            tick();
        end
        reset_n = 1'b0;
        drive(0, 16'h0000, 0, 0, 0);
        #1;
        checks++;
        if ({fifo_we, fifo_din, flush_done, overflow, line_count, drop_count} !== {1'b0, 256'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_now: we=%b din=%h fd=%b ovf=%b lines=%0d drops=%0d want all zero",
                     fifo_we, fifo_din, flush_done, overflow, line_count, drop_count);
        end
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i >= 3 && i < 19) drive(1, 16'hE000 + 16'(i - 3), 0, 0, 0);
            else                  drive(0, 16'h0000, 0, 0, 0);
            tick();
            checks++;
            if ({obs_we, obs_fd, obs_ovf, obs_lines, obs_drops} !== {exp_we, exp_fd, exp_ovf, exp_lines, exp_drops}) begin
                errors++;
                $display("FAIL reset_mid c%0d: we=%b fd=%b ovf=%b lines=%0d drops=%0d want %b %b %b %0d %0d",
                         i, obs_we, obs_fd, obs_ovf, obs_lines, obs_drops, exp_we, exp_fd, exp_ovf, exp_lines, exp_drops);
            end
            if (obs_we && !got) begin got = 1; line = obs_din; end
        end
        checks++;
        if ({got, line[15:0], line[255:240]} !== {1'b1, 16'hE000, 16'hE00F}) begin
            errors++; $display("FAIL reset_mid_line: got=%b lane0=%h lane15=%h want 1 e000 e00f", got, line[15:0], line[255:240]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 640; i++) begin
            if (i < 600) begin
                drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 39) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
                enable = ($urandom_range(0, 9) != 0);
            end else begin
                drive(0, 16'h0000, 0, 0, 0);
            end
            tick();
            checks++;
            if ({obs_we, obs_fd, obs_ovf, obs_lines, obs_drops} !== {exp_we, exp_fd, exp_ovf, exp_lines, exp_drops}) begin
                errors++;
                $display("FAIL random c%0d: we=%b fd=%b ovf=%b lines=%0d drops=%0d want %b %b %b %0d %0d",
                         i, obs_we, obs_fd, obs_ovf, obs_lines, obs_drops, exp_we, exp_fd, exp_ovf, exp_lines, exp_drops);
            end
            if (exp_we) begin
                checks++;
                if (obs_din !== exp_din) begin errors++; $display("FAIL random_din c%0d: %h want %h", i, obs_din, exp_din); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_lines();
        test_full_stall();
        test_flush_pad();
        test_flush_empty();
        test_clear_overflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
